pipe_ctrl_carrier: RTL

//  Consumes the ID-stage control word from the opcode decoder and carries it through ID/EX, EX/MEM, MEM/WB.

---
 rtl/pipe_ctrl_carrier_if.sv | 44 ++++
 rtl/pipe_ctrl_carrier.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_carrier_if.sv
// Decoder-to-pipeline control bundle: ID-stage control word in, per-stage control,
// forwarding selects and hazard handshakes out.
interface pipe_ctrl_carrier_if #(
  parameter int REG_AW = 5
);
  logic              id_valid_i;
  logic              id_RegWrite_i;
  logic              id_MemWrite_i;
  logic [1:0]        id_MemtoReg_i;
  logic              id_MemRead_i;
  logic              id_ALUSrc_i;
  logic              id_Branch_i;
  logic [1:0]        id_ALUop_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              ex_br_taken_i;
  logic [1:0]        ex_ALUop_o;
  logic              ex_ALUSrc_o;
  logic              ex_Branch_o;
  logic              mem_MemRead_o;
  logic              mem_MemWrite_o;
  logic              wb_RegWrite_o;
  logic [1:0]        wb_MemtoReg_o;
  logic [REG_AW-1:0] wb_rd_o;
  logic [1:0]        fwdA_o;
  logic [1:0]        fwdB_o;
  logic              stall_o;
  logic              flush_o;

  modport master (
    output id_valid_i, id_RegWrite_i, id_MemWrite_i, id_MemtoReg_i, id_MemRead_i,
           id_ALUSrc_i, id_Branch_i, id_ALUop_i, id_rs1_i, id_rs2_i, id_rd_i, ex_br_taken_i,
    input  ex_ALUop_o, ex_ALUSrc_o, ex_Branch_o, mem_MemRead_o, mem_MemWrite_o,
           wb_RegWrite_o, wb_MemtoReg_o, wb_rd_o, fwdA_o, fwdB_o, stall_o, flush_o
  );

  modport slave (
    input  id_valid_i, id_RegWrite_i, id_MemWrite_i, id_MemtoReg_i, id_MemRead_i,
           id_ALUSrc_i, id_Branch_i, id_ALUop_i, id_rs1_i, id_rs2_i, id_rd_i, ex_br_taken_i,
    output ex_ALUop_o, ex_ALUSrc_o, ex_Branch_o, mem_MemRead_o, mem_MemWrite_o,
           wb_RegWrite_o, wb_MemtoReg_o, wb_rd_o, fwdA_o, fwdB_o, stall_o, flush_o
  );
endinterface

// File: rtl/pipe_ctrl_carrier.sv
// Carries the decoded control word through ID/EX, EX/MEM, MEM/WB with hazard, flush and forwarding.
// Build option PIPE_FORWARD_EN: EX-stage forwarding with load-use stall; otherwise stall until writeback.
module pipe_ctrl_carrier #(
  parameter int REG_AW = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_ctrl_carrier_if.slave bus
);

  logic              vld_p0, vld_p1, vld_p2;
  logic              reg_write_p0, mem_write_p0, mem_read_p0, alu_src_p0, branch_p0;
  logic [1:0]        mem_to_reg_p0, alu_op_p0;
  logic [REG_AW-1:0] rd_p0;
  logic              reg_write_p1, mem_write_p1, mem_read_p1;
  logic [1:0]        mem_to_reg_p1;
  logic [REG_AW-1:0] rd_p1;
  logic              reg_write_p2;
  logic [1:0]        mem_to_reg_p2;
  logic [REG_AW-1:0] rd_p2;
  logic              hazard;
  logic              take_id;

  // x0 is hard-wired, so a zero destination never creates a dependency
  function automatic logic rd_hits(input logic [REG_AW-1:0] rd, rs1, rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

`ifdef PIPE_FORWARD_EN
  logic [REG_AW-1:0] rs1_p0, rs2_p0;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic mem_wr, input logic [REG_AW-1:0] mem_rd,
                                         input logic wb_wr, input logic [REG_AW-1:0] wb_rd);
    if (mem_wr && (mem_rd != '0) && (mem_rd == rs)) return 2'b10;
    if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign hazard = bus.id_valid_i & vld_p0 & mem_read_p0 & rd_hits(rd_p0, bus.id_rs1_i, bus.id_rs2_i);
  assign bus.fwdA_o = fwd_sel(rs1_p0, vld_p1 & reg_write_p1, rd_p1, vld_p2 & reg_write_p2, rd_p2);
  assign bus.fwdB_o = fwd_sel(rs2_p0, vld_p1 & reg_write_p1, rd_p1, vld_p2 & reg_write_p2, rd_p2);
`else
  // Write-before-read regfile: once the producer reaches MEM/WB the operand is readable
  assign hazard = bus.id_valid_i &
                  ((vld_p0 & reg_write_p0 & rd_hits(rd_p0, bus.id_rs1_i, bus.id_rs2_i)) |
                   (vld_p1 & reg_write_p1 & rd_hits(rd_p1, bus.id_rs1_i, bus.id_rs2_i)));
  assign bus.fwdA_o = 2'b00;
  assign bus.fwdB_o = 2'b00;
`endif

  assign take_id = bus.id_valid_i & ~hazard & ~bus.ex_br_taken_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0        <= 1'b0;
      reg_write_p0  <= 1'b0;
      mem_write_p0  <= 1'b0;
      mem_read_p0   <= 1'b0;
      alu_src_p0    <= 1'b0;
      branch_p0     <= 1'b0;
      mem_to_reg_p0 <= 2'b00;
      alu_op_p0     <= 2'b00;
      rd_p0         <= '0;
`ifdef PIPE_FORWARD_EN
      rs1_p0        <= '0;
      rs2_p0        <= '0;
`endif
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_to_reg_p1 <= 2'b00;
      rd_p1         <= '0;
      vld_p2        <= 1'b0;
      reg_write_p2  <= 1'b0;
      mem_to_reg_p2 <= 2'b00;
      rd_p2         <= '0;
    end else begin
      // ID/EX: stall, flush or an empty ID slot all load a bubble
      vld_p0        <= take_id;
      reg_write_p0  <= take_id & bus.id_RegWrite_i;
      mem_write_p0  <= take_id & bus.id_MemWrite_i;
      mem_read_p0   <= take_id & bus.id_MemRead_i;
      alu_src_p0    <= take_id & bus.id_ALUSrc_i;
      branch_p0     <= take_id & bus.id_Branch_i;
      mem_to_reg_p0 <= take_id ? bus.id_MemtoReg_i : 2'b00;
      alu_op_p0     <= take_id ? bus.id_ALUop_i : 2'b00;
      rd_p0         <= take_id ? bus.id_rd_i : '0;
`ifdef PIPE_FORWARD_EN
      rs1_p0        <= take_id ? bus.id_rs1_i : '0;
      rs2_p0        <= take_id ? bus.id_rs2_i : '0;
`endif
      // EX/MEM
      vld_p1        <= vld_p0;
      reg_write_p1  <= reg_write_p0;
      mem_write_p1  <= mem_write_p0;
      mem_read_p1   <= mem_read_p0;
      mem_to_reg_p1 <= mem_to_reg_p0;
      rd_p1         <= rd_p0;
      // MEM/WB
      vld_p2        <= vld_p1;
      reg_write_p2  <= reg_write_p1;
      mem_to_reg_p2 <= mem_to_reg_p1;
      rd_p2         <= rd_p1;
    end
  end

  assign bus.ex_ALUop_o     = alu_op_p0;
  assign bus.ex_ALUSrc_o    = alu_src_p0;
  assign bus.ex_Branch_o    = branch_p0;
  assign bus.mem_MemRead_o  = vld_p1 & mem_read_p1;
  assign bus.mem_MemWrite_o = vld_p1 & mem_write_p1;
  assign bus.wb_RegWrite_o  = vld_p2 & reg_write_p2;
  assign bus.wb_MemtoReg_o  = mem_to_reg_p2;
  assign bus.wb_rd_o        = rd_p2;
  // Flush outranks stall; both are silenced while reset is held
  assign bus.flush_o        = bus.ex_br_taken_i & ~rst_i;
  assign bus.stall_o        = hazard & ~bus.ex_br_taken_i & ~rst_i;

endmodule
